// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants,
// common to the transmitter and the planned receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words between the producer and the UART shifter.
// Pushes while full and pops while empty are dropped.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (data width, parity, stop bits, baud divisor)
// fed by a small FIFO. Parity support is compiled in with UART_TX_PARITY_EN.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 279,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          txd,
  output uart_state_t                   dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  initial begin
    if (CLKS_PER_BIT < 2) $error("CLKS_PER_BIT must be >= 2");
    if (DATA_BITS < 5 || DATA_BITS > 9) $error("DATA_BITS must be 5..9");
    if (PARITY < 0 || PARITY > 2) $error("PARITY must be 0, 1 or 2");
    if (STOP_BITS < 1 || STOP_BITS > 2) $error("STOP_BITS must be 1 or 2");
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
      $error("FIFO_DEPTH must be a power of two >= 2");
  end

  // Handshake: a word is taken on every clk edge where tx_valid && tx_ready;
  // tx_ready depends only on the FIFO count, and tx_data is captured then.
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  assign tx_ready = !fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid && tx_ready),
    .pop   (fifo_pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  uart_state_t          state_r, state_n;
  logic [CW-1:0]        cnt_r, cnt_n;
  logic [IW-1:0]        idx_r, idx_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic                 stop_r, stop_n;
  logic                 txd_r, txd_n;
  logic                 busy_r, busy_n;
  logic                 bit_done;
  logic                 par_bit;

`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = (PARITY != PAR_NONE);
  logic par_r;

  // Parity is fixed at pop time so the shifter needs no extra bookkeeping.
  always_ff @(posedge clk) begin
    if (rst)           par_r <= 1'b0;
    else if (fifo_pop) par_r <= (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
  end
  assign par_bit = par_r;
`else
  localparam bit HAS_PAR = 1'b0;
  assign par_bit = 1'b0;
`endif

  assign bit_done  = (cnt_r == CW'(CLKS_PER_BIT - 1));
  assign txd       = txd_r;
  assign busy      = busy_r;
  assign dbg_state = state_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      shift_r <= '0;
      stop_r  <= 1'b0;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      shift_r <= shift_n;
      stop_r  <= stop_n;
      txd_r   <= txd_n;
      busy_r  <= busy_n;
    end
  end

  always_comb begin
    state_n  = state_r;
    cnt_n    = bit_done ? '0 : cnt_r + 1'b1;
    idx_n    = idx_r;
    shift_n  = shift_r;
    stop_n   = stop_r;
    txd_n    = txd_r;
    busy_n   = busy_r;
    fifo_pop = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_n = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_rdata;
          txd_n    = 1'b0;
          busy_n   = 1'b1;
          state_n  = ST_START;
        end else begin
          txd_n  = 1'b1;
          busy_n = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          idx_n   = '0;
          txd_n   = shift_r[0];
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx_r == IW'(DATA_BITS - 1)) begin
            if (HAS_PAR) begin
              txd_n   = par_bit;
              state_n = ST_PARITY;
            end else begin
              txd_n   = 1'b1;
              stop_n  = 1'b0;
              state_n = ST_STOP;
            end
          end else begin
            idx_n   = idx_r + 1'b1;
            shift_n = shift_r >> 1;
            txd_n   = shift_r[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          txd_n   = 1'b1;
          stop_n  = 1'b0;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (stop_r == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when a word is waiting.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_n  = fifo_rdata;
              txd_n    = 1'b0;
              state_n  = ST_START;
            end else begin
              txd_n   = 1'b1;
              busy_n  = 1'b0;
              state_n = ST_IDLE;
            end
          end else begin
            stop_n = 1'b1;
          end
        end
      end
      default: begin
        txd_n   = 1'b1;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule
